// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS main controller: ALU operation select,
// opcode values and the registered control-word payload.
package mips_multicycle_ctrl_pkg;

    localparam int unsigned OP_W = 6;

    typedef enum logic [1:0] {
        ADD_Op    = 2'd0,
        SUB_Op    = 2'd1,
        R_Type_Op = 2'd2
    } alu_op_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // Moore control word, registered from the next state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_wr_cond;
        logic       iord;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Unified memory port between the controller (master) and the memory (slave).
interface mips_multicycle_ctrl_if;

    logic mem_req;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  iord,
        output mem_ready
    );

endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences ALU, IR, PC and the
// unified memory port, stalls on mem_ready and traps bad opcodes / memory timeouts.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [OP_W-1:0]               opcode,
    input  logic                          zero,
    input  logic                          err_clear,
    mips_multicycle_ctrl_if.master        mem_bus,
    output logic                          ir_write,
    output logic                          pc_write,
    output logic                          pc_wr_cond,
    output logic                          reg_write,
    output logic                          reg_dst,
    output logic                          mem_to_reg,
    output logic                          alu_src_a,
    output logic [1:0]                    alu_src_b,
    output alu_op_t                       alu_op,
    output logic [1:0]                    pc_src,
    output logic                          illegal_op,
    output logic                          mem_timeout
);

    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_ERR    = 4'd13
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             set_illegal, set_timeout;
    logic             wait_state, stalled;
    logic             fetch_done_c;

    // The zero flag qualifies pc_wr_cond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    // State, wait counter, control word and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        wait_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        stalled     = wait_state && !mem_bus.mem_ready;

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_ERR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ERR:    if (err_clear) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // A ready arriving on the limit cycle lets the access complete normally.
        if (stalled && (wait_cnt_q == WAIT_LIMIT)) begin
            state_d     = S_ERR;
            set_timeout = 1'b1;
        end

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (stalled) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Control word decoded from the next state so every strobe leaves a flop.
    always_comb begin
        ctrl_d        = '0;
        ctrl_d.alu_op = ADD_Op;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.alu_src_b = 2'd1;
            end
            S_DECODE: ctrl_d.alu_src_b = 2'd3;
            S_MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = R_Type_Op;
            end
            S_ALUWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_op     = SUB_Op;
                ctrl_d.pc_wr_cond = 1'b1;
                ctrl_d.pc_src     = 2'd1;
            end
            S_ADDIEX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'd2;
            end
            S_ADDIWB: ctrl_d.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 2'd2;
            end
            default: ;
        endcase

        illegal_d = (state_d == S_ERR) && (set_illegal || illegal_q);
        timeout_d = (state_d == S_ERR) && (set_timeout || timeout_q);
    end

    // IR and PC capture the fetched word on the edge that ends the fetch.
    assign fetch_done_c = (state_q == S_FETCH) && mem_bus.mem_ready;

    assign ir_write          = fetch_done_c;
    assign pc_write          = ctrl_q.pc_write || fetch_done_c;
    assign pc_wr_cond        = ctrl_q.pc_wr_cond;
    assign mem_bus.iord      = ctrl_q.iord;
    assign mem_bus.mem_req   = ctrl_q.mem_req;
    assign mem_bus.mem_write = ctrl_q.mem_write;
    assign reg_write         = ctrl_q.reg_write;
    assign reg_dst           = ctrl_q.reg_dst;
    assign mem_to_reg        = ctrl_q.mem_to_reg;
    assign alu_src_a         = ctrl_q.alu_src_a;
    assign alu_src_b         = ctrl_q.alu_src_b;
    assign alu_op            = ctrl_q.alu_op;
    assign pc_src            = ctrl_q.pc_src;
    assign illegal_op        = illegal_q;
    assign mem_timeout       = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus random instructions
// checked against per-instruction cycle/strobe totals.
module tb_mips_multicycle_ctrl;
    import mips_multicycle_ctrl_pkg::*;

    localparam int unsigned MT = 16;
    localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_BEQ = 6'h04;
    localparam logic [5:0] T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B, T_BAD = 6'h3F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       err_clear;
    logic       ir_write, pc_write, pc_wr_cond, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    alu_op_t    alu_op;
    logic       illegal_op, mem_timeout;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mips_multicycle_ctrl_if mif ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .err_clear  (err_clear),
        .mem_bus    (mif),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_wr_cond (pc_wr_cond),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pick_op(input int unsigned r);
        case (r % 6)
            0:       return T_LW;
            1:       return T_SW;
            2:       return T_R;
            3:       return T_BEQ;
            4:       return T_ADDI;
            default: return T_J;
        endcase
    endfunction

    function automatic int unsigned base_cycles(input logic [5:0] op);
        case (op)
            T_LW:               return 5;
            T_SW, T_R, T_ADDI:  return 4;
            default:            return 3;
        endcase
    endfunction

    // Runs one legal instruction from a FETCH sample point until the next FETCH,
    // then compares strobe totals with what the instruction should produce.
    task automatic run_instr(input logic [5:0] op, input int unsigned wf, input int unsigned wm);
        int unsigned cyc = 0, n_req = 0, n_irw = 0, n_pcw = 0, n_rw = 0, n_mw = 0;
        int unsigned n_cond = 0, n_sub = 0, n_rt = 0, n_flag = 0, n_badsrc = 0;
        int unsigned acc = 0, waited = 0;
        logic        mtr = 1'b0, rdst = 1'b0, done = 1'b0;
        logic        is_mem = (op == T_LW) || (op == T_SW);
        int unsigned exp_cyc = base_cycles(op) + wf + (is_mem ? wm : 0);
        opcode = op;
        zero   = 1'($urandom % 2);
        for (int c = 0; c < 120 && !done; c++) begin
            if (acc > 0 && mif.mem_req && !mif.iord) begin
                done = 1'b1;
            end else begin
                if (mif.mem_req) mif.mem_ready = (waited >= ((acc == 0) ? wf : wm));
                else             mif.mem_ready = 1'($urandom % 2);
                #1;
                cyc++;
                n_req  += 32'(mif.mem_req);
                n_mw   += 32'(mif.mem_write);
                n_irw  += 32'(ir_write);
                n_pcw  += 32'(pc_write);
                n_rw   += 32'(reg_write);
                n_cond += 32'(pc_wr_cond);
                n_sub  += 32'(alu_op == SUB_Op);
                n_rt   += 32'(alu_op == R_Type_Op);
                n_flag += 32'(illegal_op | mem_timeout);
                if (reg_write) begin
                    mtr  = mem_to_reg;
                    rdst = reg_dst;
                end
                if (pc_wr_cond && pc_src != 2'd1) n_badsrc++;
                if (mif.mem_req) begin
                    if (mif.mem_ready) begin
                        acc++;
                        waited = 0;
                    end else begin
                        waited++;
                    end
                end
                tick();
            end
        end
        chk1($sformatf("done_op%02h", op), done, 1'b1);
        chkn($sformatf("cycles_op%02h", op), cyc, exp_cyc);
        chkn($sformatf("memreq_op%02h", op), n_req, wf + 1 + (is_mem ? wm + 1 : 0));
        chkn($sformatf("memwr_op%02h", op), n_mw, (op == T_SW) ? wm + 1 : 0);
        chkn($sformatf("irw_op%02h", op), n_irw, 1);
        chkn($sformatf("pcw_op%02h", op), n_pcw, (op == T_J) ? 2 : 1);
        chkn($sformatf("regw_op%02h", op), n_rw, (op == T_LW || op == T_R || op == T_ADDI) ? 1 : 0);
        chk1($sformatf("m2r_op%02h", op), mtr, op == T_LW);
        chk1($sformatf("rdst_op%02h", op), rdst, op == T_R);
        chkn($sformatf("cond_op%02h", op), n_cond + n_badsrc, (op == T_BEQ) ? 1 : 0);
        chkn($sformatf("sub_op%02h", op), n_sub, (op == T_BEQ) ? 1 : 0);
        chkn($sformatf("rtype_op%02h", op), n_rt, (op == T_R) ? 1 : 0);
        chkn($sformatf("flags_op%02h", op), n_flag, 0);
    endtask

    initial begin
        rst_n = 1'b0; opcode = T_R; zero = 1'b0; err_clear = 1'b0; mif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_memreq", mif.mem_req, 1'b0);
        chk1("rst_irw", ir_write, 1'b0);
        chk1("rst_pcw", pc_write, 1'b0);
        chk1("rst_regw", reg_write, 1'b0);
        chkn("rst_aluop", 32'(alu_op), 32'(ADD_Op));
        chkn("rst_srcb", 32'(alu_src_b), 0);
        chk1("rst_flags", illegal_op | mem_timeout, 1'b0);

        // R-type with memory always ready
        rst_n = 1'b1; mif.mem_ready = 1'b1;
        chk1("idle_memreq", mif.mem_req, 1'b0);
        tick();
        chk1("f_memreq", mif.mem_req, 1'b1);
        chk1("f_iord", mif.iord, 1'b0);
        chk1("f_irw", ir_write, 1'b1);
        chkn("f_srcb", 32'(alu_src_b), 1);
        tick();
        chkn("d_srcb", 32'(alu_src_b), 3);
        chk1("d_memreq", mif.mem_req, 1'b0);
        tick();
        chkn("ex_aluop", 32'(alu_op), 32'(R_Type_Op));
        chk1("ex_srca", alu_src_a, 1'b1);
        tick();
        chk1("wb_regw", reg_write, 1'b1);
        chk1("wb_rdst", reg_dst, 1'b1);
        tick();
        chk1("r_back_fetch", mif.mem_req & ~mif.iord, 1'b1);

        // LW with three wait cycles in MEMRD
        run_instr(T_LW, 0, 3);

        // BEQ taken
        opcode = T_BEQ; zero = 1'b1; mif.mem_ready = 1'b1;
        tick();
        tick();
        chk1("br_cond", pc_wr_cond, 1'b1);
        chkn("br_pcsrc", 32'(pc_src), 1);
        chkn("br_aluop", 32'(alu_op), 32'(SUB_Op));
        tick();
        chk1("br_back_fetch", mif.mem_req & ~mif.iord, 1'b1);

        // Illegal opcode and recovery
        opcode = T_BAD;
        tick();
        tick();
        chk1("ill_flag", illegal_op, 1'b1);
        chk1("ill_tmo", mem_timeout, 1'b0);
        chk1("ill_strobes", reg_write | pc_write | ir_write | mif.mem_req | pc_wr_cond, 1'b0);
        tick();
        tick();
        chk1("ill_hold", illegal_op, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk1("ill_cleared", illegal_op, 1'b0);
        chk1("ill_idle", mif.mem_req, 1'b0);
        tick();
        chk1("ill_fetch", mif.mem_req & ~mif.iord, 1'b1);

        // FETCH timeout
        mif.mem_ready = 1'b0;
        repeat (MT - 1) tick();
        chk1("tmo_still_wait", mif.mem_req, 1'b1);
        chk1("tmo_not_yet", mem_timeout, 1'b0);
        tick();
        chk1("tmo_flag", mem_timeout, 1'b1);
        chk1("tmo_memreq", mif.mem_req, 1'b0);
        chk1("tmo_ill", illegal_op, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk1("tmo_cleared", mem_timeout, 1'b0);
        tick();

        // Ready on the limit cycle completes the fetch
        opcode = T_R;
        repeat (MT - 1) tick();
        mif.mem_ready = 1'b1;
        #1;
        chk1("lim_irw", ir_write, 1'b1);
        tick();
        chk1("lim_no_err", mem_timeout, 1'b0);
        chkn("lim_decode", 32'(alu_src_b), 3);
        repeat (3) tick();
        chk1("lim_back_fetch", mif.mem_req & ~mif.iord, 1'b1);

        // MEMWR timeout
        opcode = T_SW;
        repeat (3) tick();
        mif.mem_ready = 1'b0;
        chk1("wtmo_memwr", mif.mem_write, 1'b1);
        repeat (MT) tick();
        chk1("wtmo_flag", mem_timeout, 1'b1);
        chk1("wtmo_nowrite", mif.mem_write, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tick();

        // Reset in the middle of a MEMWR wait
        mif.mem_ready = 1'b1;
        repeat (3) tick();
        mif.mem_ready = 1'b0;
        repeat (2) tick();
        chk1("rw_memwr", mif.mem_write & mif.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rw_async_req", mif.mem_req, 1'b0);
        chk1("rw_async_wr", mif.mem_write, 1'b0);
        tick();
        rst_n = 1'b1;
        chk1("rw_idle", mif.mem_req, 1'b0);
        tick();
        chk1("rw_fetch", mif.mem_req & ~mif.iord, 1'b1);

        // Random legal instruction stream
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op = pick_op($urandom);
            int unsigned wf = ($urandom % 4 == 0) ? $urandom_range(0, MT - 1) : $urandom_range(0, 2);
            int unsigned wm = ($urandom % 4 == 0) ? $urandom_range(0, MT - 1) : $urandom_range(0, 2);
            run_instr(op, wf, wm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
